// File: rtl/booth_pkg.sv
// Shared types and the radix-4 Booth digit recoder for booth_mult_r4.
package booth_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} booth_state_t;

    typedef enum logic [2:0] {OP_ZERO, OP_PM, OP_P2M, OP_MM, OP_M2M} booth_op_t;

    // {Q[1], Q[0], q_m1} -> signed digit in {-2,-1,0,+1,+2} times M
    function automatic booth_op_t booth_recode(input logic [2:0] bits);
        booth_op_t op;
        case (bits)
            3'b001, 3'b010: op = OP_PM;
            3'b011:         op = OP_P2M;
            3'b100:         op = OP_M2M;
            3'b101, 3'b110: op = OP_MM;
            default:        op = OP_ZERO;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_r4_step.sv
// One radix-4 Booth iteration: add the recoded multiple of M, then
// arithmetic-shift {ACC, Q, q_m1} right by two bits.
module booth_r4_step
    import booth_pkg::*;
#(
    parameter int E = 10
) (
    input  logic [E+1:0] i_acc,
    input  logic [E-1:0] i_q,
    input  logic         i_qm1,
    input  logic [E-1:0] i_m,
    output logic [E+1:0] o_acc,
    output logic [E-1:0] o_q,
    output logic         o_qm1
);

    logic [E+1:0] w_m1;
    logic [E+1:0] w_m2;
    logic [E+1:0] w_addend;
    logic [E+1:0] w_sum;
    booth_op_t    w_op;

    assign w_m1 = {{2{i_m[E-1]}}, i_m};
    assign w_m2 = {i_m[E-1], i_m, 1'b0};
    assign w_op = booth_recode({i_q[1:0], i_qm1});

    always_comb begin
        w_addend = '0;
        case (w_op)
            OP_PM:   w_addend = w_m1;
            OP_P2M:  w_addend = w_m2;
            OP_MM:   w_addend = -w_m1;
            OP_M2M:  w_addend = -w_m2;
            default: w_addend = '0;
        endcase
    end

    assign w_sum = i_acc + w_addend;
    assign o_acc = {{2{w_sum[E+1]}}, w_sum[E+1:2]};
    assign o_q   = {w_sum[1:0], i_q[E-1:2]};
    assign o_qm1 = i_q[1];

endmodule

// File: rtl/booth_mult_r4.sv
// Radix-4 Booth multiplier, signed/unsigned per operation, valid/ready on both sides.
// Optional BOOTH_MULT_ZERO_BYPASS_EN: a zero operand finishes one edge after acceptance.
module booth_mult_r4
    import booth_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           sgn,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product
);

    localparam int E  = W + 2;
    localparam int K  = E / 2;
    localparam int CW = $clog2(K + 1);

    generate
        if (W < 4 || (W % 2) != 0) begin : g_bad_width
            $error("booth_mult_r4: W must be even and >= 4");
        end
    endgenerate

    booth_state_t   r_state;
    logic [E+1:0]   r_acc;
    logic [E-1:0]   r_q;
    logic           r_qm1;
    logic [E-1:0]   r_m;
    logic [CW-1:0]  r_cnt;
    logic           r_in_ready;
    logic           r_out_valid;
    logic [2*W-1:0] r_product;

    logic [E-1:0]   w_a_ext;
    logic [E-1:0]   w_b_ext;
    logic [E+1:0]   w_acc_n;
    logic [E-1:0]   w_q_n;
    logic           w_qm1_n;
    logic [2*W-1:0] w_prod;

    // Two extra bits keep unsigned operands positive and give the recoder a top digit
    assign w_a_ext = {{2{sgn & a[W-1]}}, a};
    assign w_b_ext = {{2{sgn & b[W-1]}}, b};

    booth_r4_step #(.E(E)) u_step (
        .i_acc (r_acc),
        .i_q   (r_q),
        .i_qm1 (r_qm1),
        .i_m   (r_m),
        .o_acc (w_acc_n),
        .o_q   (w_q_n),
        .o_qm1 (w_qm1_n)
    );

    // After K steps the exact product sits in the low 2W bits of {ACC, Q}
    assign w_prod = {w_acc_n[W-3:0], w_q_n};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_q         <= '0;
            r_qm1       <= 1'b0;
            r_m         <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_product   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_m        <= w_a_ext;
                        r_q        <= w_b_ext;
                        r_acc      <= '0;
                        r_qm1      <= 1'b0;
                        r_cnt      <= CW'(K);
                        r_state    <= CALC;
                        r_in_ready <= 1'b0;
`ifdef BOOTH_MULT_ZERO_BYPASS_EN
                        // Single all-zero step lands a zero product in DONE on the next edge
                        if (w_a_ext == '0 || w_b_ext == '0) begin
                            r_m   <= '0;
                            r_q   <= '0;
                            r_cnt <= CW'(1);
                        end
`endif
                    end
                end
                CALC: begin
                    r_acc <= w_acc_n;
                    r_q   <= w_q_n;
                    r_qm1 <= w_qm1_n;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_product   <= w_prod;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign product   = r_product;

endmodule

// File: tb/tb_booth_mult_r4.sv
// Directed-vector bench for booth_mult_r4 at W=8 and W=16 (latency depends on BOOTH_MULT_ZERO_BYPASS_EN).
module tb_booth_mult_r4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid8 = 1'b0, in_ready8, sgn8 = 1'b0, out_valid8, out_ready8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] product8;

    logic        in_valid16 = 1'b0, in_ready16, sgn16 = 1'b0, out_valid16, out_ready16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] product16;

    booth_mult_r4 #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sgn(sgn8), .out_valid(out_valid8),
        .out_ready(out_ready8), .product(product8)
    );

    booth_mult_r4 #(.W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .sgn(sgn16), .out_valid(out_valid16),
        .out_ready(out_ready16), .product(product16)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] exp;
    } vec8_t;

    int n_vec = 0;
    int n_err = 0;

`ifdef BOOTH_MULT_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 5;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                        output logic [15:0] p, output int lat);
        int g = 0;
        while (!in_ready8 && g < 50) begin @(posedge clk); #1; g++; end
        a8 = ta; b8 = tb; sgn8 = ts; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 50) begin @(posedge clk); #1; lat++; end
        p = product8;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
    endtask

    task automatic run16(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                         output logic [31:0] p, output int lat);
        int g = 0;
        while (!in_ready16 && g < 50) begin @(posedge clk); #1; g++; end
        a16 = ta; b16 = tb; sgn16 = ts; in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = 0;
        while (!out_valid16 && lat < 50) begin @(posedge clk); #1; lat++; end
        p = product16;
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
        int xi, yi, r;
        xi = s ? int'($signed(x)) : int'(x);
        yi = s ? int'($signed(y)) : int'(y);
        r  = xi * yi;
        return r[15:0];
    endfunction

    function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic s);
        longint xi, yi, r;
        xi = s ? longint'($signed(x)) : longint'(x);
        yi = s ? longint'($signed(y)) : longint'(y);
        r  = xi * yi;
        return r[31:0];
    endfunction

    initial begin
        vec8_t       tbl[$];
        logic [15:0] p8;
        logic [31:0] p16;
        int          lat;
        logic        stable;

        tbl.push_back('{8'h80, 8'h80, 1'b1, 16'h4000});
        tbl.push_back('{8'hFF, 8'hFF, 1'b0, 16'hFE01});
        tbl.push_back('{8'hFF, 8'hFF, 1'b1, 16'h0001});
        tbl.push_back('{8'hFD, 8'h05, 1'b1, 16'hFFF1});
        tbl.push_back('{8'h07, 8'h06, 1'b1, 16'h002A});
        tbl.push_back('{8'h80, 8'h80, 1'b0, 16'h4000});
        tbl.push_back('{8'h7F, 8'h80, 1'b1, 16'hC080});
        tbl.push_back('{8'hFF, 8'h01, 1'b1, 16'hFFFF});
        tbl.push_back('{8'hFF, 8'h01, 1'b0, 16'h00FF});
        tbl.push_back('{8'h12, 8'h34, 1'b0, 16'h03A8});

        #12 rst = 1'b0;
        @(posedge clk); #1;
        chk("reset in_ready", {31'd0, in_ready8}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid8}, 32'd0);
        chk("reset product", {16'd0, product8}, 32'd0);

        // Stray out_ready while idle must do nothing
        out_ready8 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        out_ready8 = 1'b0;
        chk("spurious out_ready", {30'd0, in_ready8, out_valid8}, 32'd2);

        foreach (tbl[i]) begin
            run8(tbl[i].a, tbl[i].b, tbl[i].s, p8, lat);
            chk($sformatf("vec%0d product", i), {16'd0, p8}, {16'd0, tbl[i].exp});
            chk($sformatf("vec%0d latency", i), lat, 32'd5);
        end

        run8(8'h00, 8'h5A, 1'b1, p8, lat);
        chk("zero product", {16'd0, p8}, 32'd0);
        chk("zero latency", lat, ZLAT);
        run8(8'hA5, 8'h00, 1'b0, p8, lat);
        chk("zero b product", {16'd0, p8}, 32'd0);

        // Backpressure: hold the result, ignore new operands
        a8 = 8'hFD; b8 = 8'h05; sgn8 = 1'b1; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 50) begin @(posedge clk); #1; lat++; end
        chk("bp product", {16'd0, product8}, 32'h0000FFF1);
        a8 = 8'h11; b8 = 8'h22; sgn8 = 1'b0; in_valid8 = 1'b1;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (!out_valid8 || in_ready8 || product8 !== 16'hFFF1) stable = 1'b0;
        end
        chk("bp stable", {31'd0, stable}, 32'd1);
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        chk("bp release", {30'd0, in_ready8, out_valid8}, 32'd2);
        repeat (3) @(posedge clk);
        #1;
        chk("bp no queued op", {15'd0, out_valid8, product8}, 32'h0000FFF1);

        // Reset at the 3rd CALC edge
        a8 = 8'h03; b8 = 8'h09; sgn8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midreset state", {15'd0, in_ready8, out_valid8, product8}, 32'h00020000);
        repeat (6) @(posedge clk);
        #1;
        chk("midreset no result", {31'd0, out_valid8}, 32'd0);
        run8(8'h07, 8'h06, 1'b0, p8, lat);
        chk("after reset 7*6", {16'd0, p8}, 32'h0000002A);

        run16(16'h7FFF, 16'h8000, 1'b1, p16, lat);
        chk("w16 7FFF*8000", p16, 32'hC0008000);
        chk("w16 latency", lat, 32'd9);
        run16(16'hFFFF, 16'hFFFF, 1'b0, p16, lat);
        chk("w16 unsigned ones", p16, 32'hFFFE0001);
        run16(16'h8000, 16'h8000, 1'b1, p16, lat);
        chk("w16 minneg sq", p16, 32'h40000000);

        for (int i = 0; i < 200; i++) begin
            logic [7:0] ra, rb;
            logic       rs;
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            run8(ra, rb, rs, p8, lat);
            chk($sformatf("rnd8 %h*%h s%0d", ra, rb, rs), {16'd0, p8}, {16'd0, ref8(ra, rb, rs)});
        end
        for (int i = 0; i < 100; i++) begin
            logic [15:0] ra, rb;
            logic        rs;
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            run16(ra, rb, rs, p16, lat);
            chk($sformatf("rnd16 %h*%h s%0d", ra, rb, rs), p16, ref16(ra, rb, rs));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
